// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion and flush; 1-cycle latency.
// Valid/ready handshake: in_ready drops on downstream stall, load-use hazard or flush.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_ra,
    input  logic [4:0]  in_rb,
    input  logic [4:0]  in_rw,
    input  logic [31:0] in_busA,
    input  logic [31:0] in_busB,
    input  logic [31:0] in_imm,
    input  logic [7:0]  in_ctrl,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_busW,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_busA,
    output logic [31:0] out_busB,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rw,
    output logic [7:0]  out_ctrl,
    output logic        hazard_stall,
    output logic [15:0] bubble_count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;

    logic capture;
    logic held_load;

    assign out_valid = (state == FULL);
    // Held instruction is a load (MemRead) that also writes a register.
    assign held_load    = out_valid && out_ctrl[1] && out_ctrl[0];
    assign hazard_stall = held_load && in_valid && ((out_rw == in_ra) || (out_rw == in_rb));
    assign in_ready     = (!out_valid || out_ready) && !hazard_stall && !flush;
    assign capture      = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= EMPTY;
            out_busA     <= 32'd0;
            out_busB     <= 32'd0;
            out_imm      <= 32'd0;
            out_rw       <= 5'd0;
            out_ctrl     <= 8'd0;
            bubble_count <= 16'd0;
        end else if (flush) begin
            state    <= EMPTY;
            out_ctrl <= 8'd0;
        end else if (capture) begin
            state    <= FULL;
            // Register file writes this cycle are not yet visible on the read buses.
            out_busA <= (wb_regwrite && (wb_rw == in_ra)) ? wb_busW : in_busA;
            out_busB <= (wb_regwrite && (wb_rw == in_rb)) ? wb_busW : in_busB;
            out_imm  <= in_imm;
            out_rw   <= in_rw;
            out_ctrl <= in_ctrl;
        end else if (out_valid && out_ready) begin
            state    <= EMPTY;
            out_ctrl <= 8'd0;
            if (hazard_stall && (bubble_count != 16'hFFFF))
                bubble_count <= bubble_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: model tracks occupancy, hazards and bubble count.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_ra = '0, in_rb = '0, in_rw = '0;
    logic [31:0] in_busA = '0, in_busB = '0, in_imm = '0;
    logic [7:0]  in_ctrl = '0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rw = '0;
    logic [31:0] wb_busW = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_busA, out_busB, out_imm;
    logic [4:0]  out_rw;
    logic [7:0]  out_ctrl;
    logic        hazard_stall;
    logic [15:0] bubble_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rw;
        logic [7:0]  ctrl;
    } item_t;

    item_t       q[$];
    logic [15:0] m_bub = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rw(in_rw), .in_busA(in_busA), .in_busB(in_busB),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .wb_regwrite(wb_regwrite), .wb_rw(wb_rw),
        .wb_busW(wb_busW), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_busA(out_busA), .out_busB(out_busB), .out_imm(out_imm), .out_rw(out_rw),
        .out_ctrl(out_ctrl), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a falling edge: drive, check, predict, then advance one cycle.
    task automatic cyc(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic fl, input logic ordy);
        logic  full, haz, rdy;
        item_t it;
        in_valid = v; in_ra = ra; in_rb = rb; in_rw = rw; in_busA = a; in_busB = b;
        in_imm = imm; in_ctrl = ctrl; flush = fl; out_ready = ordy;
        #1;
        full = (q.size() != 0);
        haz  = full && (q[0].ctrl[1:0] == 2'b11) && v && ((q[0].rw == ra) || (q[0].rw == rb));
        rdy  = (!full || ordy) && !haz && !fl;
        check("out_valid", {31'd0, out_valid}, {31'd0, full});
        check("hazard_stall", {31'd0, hazard_stall}, {31'd0, haz});
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        check("bubble_count", {16'd0, bubble_count}, {16'd0, m_bub});
        if (full) begin
            check("out_busA", out_busA, q[0].a);
            check("out_busB", out_busB, q[0].b);
            check("out_imm", out_imm, q[0].imm);
            check("out_rw", {27'd0, out_rw}, {27'd0, q[0].rw});
            check("out_ctrl", {24'd0, out_ctrl}, {24'd0, q[0].ctrl});
        end else begin
            check("out_ctrl_empty", {24'd0, out_ctrl}, 32'd0);
        end
        if (fl) begin
            q.delete();
        end else if (v && rdy) begin
            if (full) void'(q.pop_front());
            it.a    = (wb_regwrite && (wb_rw == ra)) ? wb_busW : a;
            it.b    = (wb_regwrite && (wb_rw == rb)) ? wb_busW : b;
            it.imm  = imm;
            it.rw   = rw;
            it.ctrl = ctrl;
            q.push_back(it);
        end else if (full && ordy) begin
            void'(q.pop_front());
            if (haz && (m_bub != 16'hFFFF)) m_bub = m_bub + 16'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busA", out_busA, 32'd0);
        check("rst_busB", out_busB, 32'd0);
        check("rst_imm", out_imm, 32'd0);
        check("rst_rw", {27'd0, out_rw}, 32'd0);
        check("rst_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("rst_bubbles", {16'd0, bubble_count}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Back-to-back captures with consume (no gap cycles)
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 10), 32'h100 + i, 32'h200 + i,
                32'h300 + i, 8'h01 | 8'(i << 4), 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        // WB bypass on A only, then on index 0 for both operands
        wb_regwrite = 1'b1; wb_rw = 5'd7; wb_busW = 32'hDEAD_BEEF;
        cyc(1'b1, 5'd7, 5'd8, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h4, 8'h01, 1'b0, 1'b1);
        wb_rw = 5'd0; wb_busW = 32'hCAFE_0000;
        cyc(1'b1, 5'd0, 5'd0, 5'd3, 32'h5, 32'h6, 32'h7, 8'h01, 1'b0, 1'b1);
        wb_regwrite = 1'b0;
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        // Back-pressure for 3 cycles, then release loads new instruction on the same edge
        cyc(1'b1, 5'd1, 5'd2, 5'd9, 32'hA, 32'hB, 32'hC, 8'h11, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 5'd3, 5'd4, 5'd6, 32'hD, 32'hE, 32'hF, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 5'd4, 5'd6, 32'hD, 32'hE, 32'hF, 8'h21, 1'b0, 1'b1);

        // Load-use: bubble inserted, dependent instruction captured next cycle
        cyc(1'b1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h30, 8'h03, 1'b0, 1'b1);
        cyc(1'b1, 5'd5, 5'd2, 5'd6, 32'h40, 32'h50, 32'h60, 8'h01, 1'b0, 1'b1);
        cyc(1'b1, 5'd5, 5'd2, 5'd6, 32'h40, 32'h50, 32'h60, 8'h01, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        // Hazard on rb while stalled downstream: no bubble counted
        cyc(1'b1, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h3, 8'h03, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 5'd4, 5'd9, 5'd6, 32'h7, 32'h8, 32'h9, 8'h01, 1'b0, 1'b0);

        // Flush drops both held and incoming instructions
        cyc(1'b1, 5'd4, 5'd1, 5'd6, 32'h7, 32'h8, 32'h9, 8'h01, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        // Saturation: preset near the top, then force more bubbles than remain
        force dut.bubble_count = 16'hFFFD;
        #1 release dut.bubble_count;
        m_bub = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h30, 8'h03, 1'b0, 1'b1);
            cyc(1'b1, 5'd5, 5'd2, 5'd6, 32'h40, 32'h50, 32'h60, 8'h01, 1'b0, 1'b1);
        end
        check("sat_value", {16'd0, bubble_count}, 32'h0000_FFFF);

        // Randomized traffic with loads, flushes, bypass and back-pressure
        for (int i = 0; i < 400; i++) begin
            wb_regwrite = 1'($urandom);
            wb_rw       = 5'($urandom_range(0, 7));
            wb_busW     = $urandom;
            cyc(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                8'($urandom) | ($urandom_range(0, 1) != 0 ? 8'h03 : 8'h00),
                ($urandom_range(0, 9) == 0), 1'($urandom));
        end
        wb_regwrite = 1'b0;

        // Reset mid-stream between edges while a load is held
        cyc(1'b1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h30, 8'h03, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("midrst_bubbles", {16'd0, bubble_count}, 32'd0);
        check("midrst_busA", out_busA, 32'd0);
        #1 reset = 1'b1;
        q.delete();
        m_bub = '0;
        @(negedge clk);
        cyc(1'b1, 5'd2, 5'd3, 5'd4, 32'h77, 32'h88, 32'h99, 8'h05, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
